id_ex_stage: RTL and testbench

//  ID/EX pipeline stage. Latches decoded control (from the datapath controller) and ID operands into EX.

---
 rtl/id_ex_stage.sv | 195 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register. Captures the decoded control word and the ID
//   operands into EX, resolves the destination register, and detects
//   load-use hazards against the instruction currently held in EX.
//   A load-use hazard inserts one bubble and freezes PC and IF/ID.
//   Branch/jump flushes and downstream stalls are applied here, and
//   inserted load-use bubbles are counted (saturating) for debug.
//
// Ports
//   Clock, Reset             rising-edge clock, synchronous active-high reset
//   Flush                    kill the instruction entering EX
//   Stall                    hold EX contents
//   ID_*                     decoded control, operands and register fields
//   EX_*                     registered copies of ID_* (no UsesRt/RegDest)
//   EX_WriteReg              resolved destination register
//   EX_Valid                 EX holds a real instruction
//   PCWrite, IFIDWrite       fetch-side enables (low on stall or hazard)
//   BubbleCount              saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5,
  parameter int LINK_REG   = 31,
  parameter int CNT_W      = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Flush,
  input  logic                  Stall,
  input  logic [1:0]            ID_RegDest,
  input  logic                  ID_RegWrite,
  input  logic                  ID_AluSrc,
  input  logic                  ID_MemWrite,
  input  logic                  ID_MemRead,
  input  logic                  ID_Branch,
  input  logic                  ID_JAL,
  input  logic                  ID_LB4,
  input  logic [4:0]            ID_AluOp,
  input  logic [1:0]            ID_MemToReg,
  input  logic [1:0]            ID_ByteSel,
  input  logic [2:0]            ID_BCControl,
  input  logic                  ID_UsesRt,
  input  logic [DATA_WIDTH-1:0] ID_ReadData1,
  input  logic [DATA_WIDTH-1:0] ID_ReadData2,
  input  logic [DATA_WIDTH-1:0] ID_Imm,
  input  logic [DATA_WIDTH-1:0] ID_PCPlus4,
  input  logic [REG_AW-1:0]     ID_Rs,
  input  logic [REG_AW-1:0]     ID_Rt,
  input  logic [REG_AW-1:0]     ID_Rd,
  output logic                  EX_RegWrite,
  output logic                  EX_AluSrc,
  output logic                  EX_MemWrite,
  output logic                  EX_MemRead,
  output logic                  EX_Branch,
  output logic                  EX_JAL,
  output logic                  EX_LB4,
  output logic [4:0]            EX_AluOp,
  output logic [1:0]            EX_MemToReg,
  output logic [1:0]            EX_ByteSel,
  output logic [2:0]            EX_BCControl,
  output logic [DATA_WIDTH-1:0] EX_ReadData1,
  output logic [DATA_WIDTH-1:0] EX_ReadData2,
  output logic [DATA_WIDTH-1:0] EX_Imm,
  output logic [DATA_WIDTH-1:0] EX_PCPlus4,
  output logic [REG_AW-1:0]     EX_Rs,
  output logic [REG_AW-1:0]     EX_Rt,
  output logic [REG_AW-1:0]     EX_Rd,
  output logic [REG_AW-1:0]     EX_WriteReg,
  output logic                  EX_Valid,
  output logic                  PCWrite,
  output logic                  IFIDWrite,
  output logic [CNT_W-1:0]      BubbleCount
);

  typedef struct packed {
    logic                  reg_write;
    logic                  alu_src;
    logic                  mem_write;
    logic                  mem_read;
    logic                  branch;
    logic                  jal;
    logic                  lb4;
    logic [4:0]            alu_op;
    logic [1:0]            mem_to_reg;
    logic [1:0]            byte_sel;
    logic [2:0]            bc_control;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [REG_AW-1:0]     rs;
    logic [REG_AW-1:0]     rt;
    logic [REG_AW-1:0]     rd;
    logic [REG_AW-1:0]     write_reg;
    logic                  valid;
  } ex_bundle_t;

  localparam logic [REG_AW-1:0] LINK_ADDR = REG_AW'(LINK_REG);

  ex_bundle_t        r_ex_p1;
  ex_bundle_t        w_id_p0;
  logic [CNT_W-1:0]  r_bubble_cnt_p1;
  logic [REG_AW-1:0] w_write_reg_p0;
  logic              w_load_use_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // ---- ID stage: destination decode, hazard detect, fetch enables ----
  always_comb begin
    w_write_reg_p0 = '0;
    case (ID_RegDest)
      2'b00:   w_write_reg_p0 = ID_Rd;
      2'b01:   w_write_reg_p0 = ID_Rt;
      2'b10:   w_write_reg_p0 = LINK_ADDR;
      default: w_write_reg_p0 = '0;
    endcase
  end

  // A load writing $0 never creates a dependency; Rt only matters when the
  // ID instruction actually reads it as a source.
  assign w_load_use_p0 = r_ex_p1.valid & r_ex_p1.mem_read & r_ex_p1.reg_write
                       & (r_ex_p1.write_reg != '0)
                       & ((r_ex_p1.write_reg == ID_Rs)
                          | (ID_UsesRt & (r_ex_p1.write_reg == ID_Rt)));

  // Flush overrides the hazard freeze so the PC can take the branch target.
  assign PCWrite   = Reset | (~Stall & ~(w_load_use_p0 & ~Flush));
  assign IFIDWrite = PCWrite;

  assign w_id_p0 = '{
    reg_write:  ID_RegWrite,
    alu_src:    ID_AluSrc,
    mem_write:  ID_MemWrite,
    mem_read:   ID_MemRead,
    branch:     ID_Branch,
    jal:        ID_JAL,
    lb4:        ID_LB4,
    alu_op:     ID_AluOp,
    mem_to_reg: ID_MemToReg,
    byte_sel:   ID_ByteSel,
    bc_control: ID_BCControl,
    rd1:        ID_ReadData1,
    rd2:        ID_ReadData2,
    imm:        ID_Imm,
    pc_plus4:   ID_PCPlus4,
    rs:         ID_Rs,
    rt:         ID_Rt,
    rd:         ID_Rd,
    write_reg:  w_write_reg_p0,
    valid:      1'b1
  };

  // ---- ID -> EX register ----
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_ex_p1         <= '0;
      r_bubble_cnt_p1 <= '0;
    end else if (Flush) begin
      r_ex_p1 <= '0;
    end else if (Stall) begin
      r_ex_p1 <= r_ex_p1;
    end else if (w_load_use_p0) begin
      r_ex_p1         <= '0;
      r_bubble_cnt_p1 <= sat_inc(r_bubble_cnt_p1);
    end else begin
      r_ex_p1 <= w_id_p0;
    end
  end

  assign EX_RegWrite  = r_ex_p1.reg_write;
  assign EX_AluSrc    = r_ex_p1.alu_src;
  assign EX_MemWrite  = r_ex_p1.mem_write;
  assign EX_MemRead   = r_ex_p1.mem_read;
  assign EX_Branch    = r_ex_p1.branch;
  assign EX_JAL       = r_ex_p1.jal;
  assign EX_LB4       = r_ex_p1.lb4;
  assign EX_AluOp     = r_ex_p1.alu_op;
  assign EX_MemToReg  = r_ex_p1.mem_to_reg;
  assign EX_ByteSel   = r_ex_p1.byte_sel;
  assign EX_BCControl = r_ex_p1.bc_control;
  assign EX_ReadData1 = r_ex_p1.rd1;
  assign EX_ReadData2 = r_ex_p1.rd2;
  assign EX_Imm       = r_ex_p1.imm;
  assign EX_PCPlus4   = r_ex_p1.pc_plus4;
  assign EX_Rs        = r_ex_p1.rs;
  assign EX_Rt        = r_ex_p1.rt;
  assign EX_Rd        = r_ex_p1.rd;
  assign EX_WriteReg  = r_ex_p1.write_reg;
  assign EX_Valid     = r_ex_p1.valid;
  assign BubbleCount  = r_bubble_cnt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: spec-level model plus directed vectors.
module tb_id_ex_stage;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          Clock = 1'b0;
  logic          Reset, Flush, Stall;
  logic [1:0]    ID_RegDest;
  logic          ID_RegWrite, ID_AluSrc, ID_MemWrite, ID_MemRead, ID_Branch, ID_JAL, ID_LB4;
  logic [4:0]    ID_AluOp;
  logic [1:0]    ID_MemToReg, ID_ByteSel;
  logic [2:0]    ID_BCControl;
  logic          ID_UsesRt;
  logic [DW-1:0] ID_ReadData1, ID_ReadData2, ID_Imm, ID_PCPlus4;
  logic [AW-1:0] ID_Rs, ID_Rt, ID_Rd;

  logic          EX_RegWrite, EX_AluSrc, EX_MemWrite, EX_MemRead, EX_Branch, EX_JAL, EX_LB4;
  logic [4:0]    EX_AluOp;
  logic [1:0]    EX_MemToReg, EX_ByteSel;
  logic [2:0]    EX_BCControl;
  logic [DW-1:0] EX_ReadData1, EX_ReadData2, EX_Imm, EX_PCPlus4;
  logic [AW-1:0] EX_Rs, EX_Rt, EX_Rd, EX_WriteReg;
  logic          EX_Valid, PCWrite, IFIDWrite;
  logic [CW-1:0] BubbleCount;

  always #5 Clock = ~Clock;

  id_ex_stage #(.DATA_WIDTH(DW), .REG_AW(AW), .LINK_REG(31), .CNT_W(CW)) dut (
    .Clock(Clock), .Reset(Reset), .Flush(Flush), .Stall(Stall),
    .ID_RegDest(ID_RegDest), .ID_RegWrite(ID_RegWrite), .ID_AluSrc(ID_AluSrc),
    .ID_MemWrite(ID_MemWrite), .ID_MemRead(ID_MemRead), .ID_Branch(ID_Branch),
    .ID_JAL(ID_JAL), .ID_LB4(ID_LB4), .ID_AluOp(ID_AluOp), .ID_MemToReg(ID_MemToReg),
    .ID_ByteSel(ID_ByteSel), .ID_BCControl(ID_BCControl), .ID_UsesRt(ID_UsesRt),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm),
    .ID_PCPlus4(ID_PCPlus4), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .EX_RegWrite(EX_RegWrite), .EX_AluSrc(EX_AluSrc), .EX_MemWrite(EX_MemWrite),
    .EX_MemRead(EX_MemRead), .EX_Branch(EX_Branch), .EX_JAL(EX_JAL), .EX_LB4(EX_LB4),
    .EX_AluOp(EX_AluOp), .EX_MemToReg(EX_MemToReg), .EX_ByteSel(EX_ByteSel),
    .EX_BCControl(EX_BCControl), .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2),
    .EX_Imm(EX_Imm), .EX_PCPlus4(EX_PCPlus4), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
    .EX_WriteReg(EX_WriteReg), .EX_Valid(EX_Valid), .PCWrite(PCWrite),
    .IFIDWrite(IFIDWrite), .BubbleCount(BubbleCount)
  );

  typedef struct packed {
    logic          rw, alusrc, mw, mr, br, jal, lb4;
    logic [4:0]    aluop;
    logic [1:0]    m2r, bsel;
    logic [2:0]    bc;
    logic [DW-1:0] rd1, rd2, imm, pc4;
    logic [AW-1:0] rs, rt, rd, wr;
    logic          valid;
  } ex_t;

  ex_t           dut_ex, m_ex;
  logic [CW-1:0] m_cnt = '0;
  logic          chk_en = 1'b0;
  int            errors = 0;
  int            checks = 0;

  assign dut_ex = {EX_RegWrite, EX_AluSrc, EX_MemWrite, EX_MemRead, EX_Branch, EX_JAL, EX_LB4,
                   EX_AluOp, EX_MemToReg, EX_ByteSel, EX_BCControl,
                   EX_ReadData1, EX_ReadData2, EX_Imm, EX_PCPlus4,
                   EX_Rs, EX_Rt, EX_Rd, EX_WriteReg, EX_Valid};

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- model ----
  function automatic logic [AW-1:0] dest(input logic [1:0] sel);
    if (sel == 2'b00) return ID_Rd;
    if (sel == 2'b01) return ID_Rt;
    if (sel == 2'b10) return AW'(31);
    return '0;
  endfunction

  function automatic logic hazard();
    // the EX instruction is a real load writing a nonzero register that ID reads
    if (!(m_ex.valid && m_ex.mr && m_ex.rw) || m_ex.wr == 0) return 1'b0;
    return (m_ex.wr == ID_Rs) || (ID_UsesRt && m_ex.wr == ID_Rt);
  endfunction

  function automatic logic exp_fetch();
    if (Reset) return 1'b1;
    return !(Stall || (hazard() && !Flush));
  endfunction

  initial m_ex = '0;

  always @(posedge Clock) begin
    if (Reset) begin
      m_ex  = '0;
      m_cnt = '0;
    end else if (Flush) begin
      m_ex = '0;
    end else if (Stall) begin
      m_ex = m_ex;
    end else if (hazard()) begin
      m_ex = '0;
      if (m_cnt != CMAX) m_cnt = m_cnt + 1'b1;
    end else begin
      m_ex = {ID_RegWrite, ID_AluSrc, ID_MemWrite, ID_MemRead, ID_Branch, ID_JAL, ID_LB4,
              ID_AluOp, ID_MemToReg, ID_ByteSel, ID_BCControl,
              ID_ReadData1, ID_ReadData2, ID_Imm, ID_PCPlus4,
              ID_Rs, ID_Rt, ID_Rd, dest(ID_RegDest), 1'b1};
    end
  end

  // ---- compare process ----
  always @(negedge Clock) begin
    if (chk_en) begin
      chk("ex_bundle", 200'(dut_ex), 200'(m_ex));
      chk("bubble_cnt", 200'(BubbleCount), 200'(m_cnt));
      chk("pcwrite", 200'(PCWrite), 200'(exp_fetch()));
      chk("ifidwrite", 200'(IFIDWrite), 200'(exp_fetch()));
    end
  end

  // ---- stimulus helpers ----
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic id_clear();
    Flush = 0; Stall = 0;
    ID_RegDest = 2'b11; ID_RegWrite = 0; ID_AluSrc = 0; ID_MemWrite = 0; ID_MemRead = 0;
    ID_Branch = 0; ID_JAL = 0; ID_LB4 = 0; ID_AluOp = '0; ID_MemToReg = '0;
    ID_ByteSel = '0; ID_BCControl = '0; ID_UsesRt = 0;
    ID_ReadData1 = '0; ID_ReadData2 = '0; ID_Imm = '0; ID_PCPlus4 = '0;
    ID_Rs = '0; ID_Rt = '0; ID_Rd = '0;
  endtask

  task automatic id_lw(input logic [AW-1:0] rt);
    id_clear();
    ID_RegDest = 2'b01; ID_Rs = 5'd2; ID_Rt = rt; ID_MemRead = 1; ID_RegWrite = 1;
    ID_MemToReg = 2'b01; ID_AluSrc = 1; ID_AluOp = 5'd1; ID_ByteSel = 2'b11;
    ID_Imm = 32'h10; ID_ReadData1 = 32'h100; ID_PCPlus4 = 32'h40;
  endtask

  task automatic id_add(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd);
    id_clear();
    ID_RegDest = 2'b00; ID_Rs = rs; ID_Rt = rt; ID_Rd = rd; ID_RegWrite = 1; ID_UsesRt = 1;
    ID_AluOp = 5'd2; ID_ReadData1 = 32'h11; ID_ReadData2 = 32'h22; ID_PCPlus4 = 32'h44;
  endtask

  initial begin
    // reset with every ID input nonzero
    Reset = 1; Flush = 0; Stall = 0;
    ID_RegDest = 2'b01; ID_RegWrite = 1; ID_AluSrc = 1; ID_MemWrite = 1; ID_MemRead = 1;
    ID_Branch = 1; ID_JAL = 1; ID_LB4 = 1; ID_AluOp = 5'h1f; ID_MemToReg = 2'b11;
    ID_ByteSel = 2'b11; ID_BCControl = 3'h7; ID_UsesRt = 1;
    ID_ReadData1 = 32'hdead_beef; ID_ReadData2 = 32'h1234_5678; ID_Imm = 32'hffff;
    ID_PCPlus4 = 32'h400; ID_Rs = 5'd3; ID_Rt = 5'd4; ID_Rd = 5'd6;
    tick();
    chk_en = 1;
    chk("rst_valid", 200'(EX_Valid), 200'(0));
    chk("rst_cnt", 200'(BubbleCount), 200'(0));
    chk("rst_imm", 200'(EX_Imm), 200'(0));
    chk("rst_pcwrite", 200'(PCWrite), 200'(1));
    tick();
    Reset = 0;

    // ADDI $5
    id_clear();
    ID_RegDest = 2'b01; ID_Rs = 5'd1; ID_Rt = 5'd5; ID_RegWrite = 1; ID_AluSrc = 1; ID_Imm = 32'h4;
    tick();
    chk("addi_wr", 200'(EX_WriteReg), 200'(5));
    chk("addi_imm", 200'(EX_Imm), 200'(4));
    chk("addi_valid", 200'(EX_Valid), 200'(1));

    // LW $8 then ADD using $8
    id_lw(5'd8);
    tick();
    id_add(5'd8, 5'd9, 5'd10);
    #1;
    chk("lu_pcwrite", 200'(PCWrite), 200'(0));
    chk("lu_ifid", 200'(IFIDWrite), 200'(0));
    tick();
    chk("lu_bubble_valid", 200'(EX_Valid), 200'(0));
    chk("lu_cnt", 200'(BubbleCount), 200'(1));
    chk("lu_pc_after", 200'(PCWrite), 200'(1));
    tick();
    chk("lu_add_wr", 200'(EX_WriteReg), 200'(10));
    chk("lu_add_valid", 200'(EX_Valid), 200'(1));

    // LW to $0 then use of $0
    id_lw(5'd0);
    tick();
    id_add(5'd0, 5'd0, 5'd3);
    #1;
    chk("zero_pcwrite", 200'(PCWrite), 200'(1));
    tick();
    chk("zero_wr", 200'(EX_WriteReg), 200'(3));
    chk("zero_cnt", 200'(BubbleCount), 200'(1));

    // LW $8 then ORI with Rt=8 not used as source
    id_lw(5'd8);
    tick();
    id_clear();
    ID_RegDest = 2'b01; ID_Rs = 5'd3; ID_Rt = 5'd8; ID_RegWrite = 1; ID_AluSrc = 1; ID_Imm = 32'hff;
    #1;
    chk("ori_pcwrite", 200'(PCWrite), 200'(1));
    tick();
    chk("ori_valid", 200'(EX_Valid), 200'(1));
    chk("ori_wr", 200'(EX_WriteReg), 200'(8));

    // Flush + Stall + LoadUse together
    id_lw(5'd8);
    tick();
    id_add(5'd8, 5'd9, 5'd10);
    Flush = 1; Stall = 1;
    #1;
    chk("fsl_pcwrite", 200'(PCWrite), 200'(0));
    tick();
    chk("fsl_valid", 200'(EX_Valid), 200'(0));
    chk("fsl_cnt", 200'(BubbleCount), 200'(1));

    // Flush alone
    id_add(5'd4, 5'd5, 5'd6);
    tick();
    id_add(5'd1, 5'd2, 5'd7);
    Flush = 1;
    #1;
    chk("flush_pcwrite", 200'(PCWrite), 200'(1));
    tick();
    chk("flush_valid", 200'(EX_Valid), 200'(0));

    // Stall with a pending load-use: hold, then bubble once stall drops
    id_lw(5'd8);
    tick();
    id_add(5'd8, 5'd9, 5'd10);
    Stall = 1;
    #1;
    chk("stall_pcwrite", 200'(PCWrite), 200'(0));
    tick();
    chk("stall_hold_wr", 200'(EX_WriteReg), 200'(8));
    chk("stall_hold_mr", 200'(EX_MemRead), 200'(1));
    chk("stall_cnt", 200'(BubbleCount), 200'(1));
    Stall = 0;
    tick();
    chk("unstall_valid", 200'(EX_Valid), 200'(0));
    chk("unstall_cnt", 200'(BubbleCount), 200'(2));
    tick();

    // JAL
    id_clear();
    ID_RegDest = 2'b10; ID_JAL = 1; ID_RegWrite = 1; ID_PCPlus4 = 32'h1000_0008;
    tick();
    chk("jal_wr", 200'(EX_WriteReg), 200'(31));
    chk("jal_jal", 200'(EX_JAL), 200'(1));
    chk("jal_pc4", 200'(EX_PCPlus4), 200'(32'h1000_0008));

    // RegDest none
    id_clear();
    ID_RegDest = 2'b11; ID_Rd = 5'd12; ID_Rt = 5'd13;
    tick();
    chk("none_wr", 200'(EX_WriteReg), 200'(0));

    // saturation: 20 more bubbles
    for (int i = 0; i < 20; i++) begin
      id_lw(5'd8);
      tick();
      id_add(5'd8, 5'd9, 5'd10);
      tick();
      tick();
    end
    chk("sat_cnt", 200'(BubbleCount), 200'(15));

    // reset while stalled
    id_lw(5'd8);
    tick();
    id_add(5'd8, 5'd9, 5'd10);
    Stall = 1;
    tick();
    Reset = 1;
    #1;
    chk("rst_stall_pcwrite", 200'(PCWrite), 200'(1));
    tick();
    chk("rst_stall_valid", 200'(EX_Valid), 200'(0));
    chk("rst_stall_cnt", 200'(BubbleCount), 200'(0));
    Reset = 0;
    id_clear();
    tick();
    @(negedge Clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
